// File: rtl/position_delta_serial.sv
// Bit-serial signed displacement: delta = target - current, LSB first through one full-adder cell.
// Produces |delta| as magnitude plus a direction bit; a borrowed result is negated serially.
module position_delta_serial #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] current,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] magnitude,
  output logic             dir,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    count;
  logic             carry;
  logic             borrow;

  logic fa_a;
  logic fa_b;
  logic fa_sum;
  logic fa_cout;

  // The single adder cell: A + ~B + c while subtracting, ~R + 0 + c while negating.
  always_comb begin
    fa_a = a_q[0];
    fa_b = ~b_q[0];
    if (state == NEG) begin
      fa_a = ~res_q[0];
      fa_b = 1'b0;
    end
  end

  assign fa_sum  = fa_a ^ fa_b ^ carry;
  assign fa_cout = (fa_a & fa_b) | (carry & (fa_a ^ fa_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      count     <= '0;
      carry     <= 1'b0;
      borrow    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      magnitude <= '0;
      dir       <= 1'b0;
      zero      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= target;
            b_q   <= current;
            carry <= 1'b1;
            count <= '0;
            busy  <= 1'b1;
            state <= SUB;
          end
        end
        SUB: begin
          res_q <= {fa_sum, res_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          count <= count + CW'(1);
          carry <= fa_cout;
          // A final carry of 0 is a borrow: the result is negative and needs negating.
          if (count == CW'(WIDTH - 1)) begin
            count  <= '0;
            borrow <= ~fa_cout;
            if (fa_cout) begin
              state <= DONE;
            end else begin
              carry <= 1'b1;
              state <= NEG;
            end
          end
        end
        NEG: begin
          res_q <= {fa_sum, res_q[WIDTH-1:1]};
          carry <= fa_cout;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            count <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          magnitude <= res_q;
          dir       <= borrow;
          zero      <= (res_q == '0);
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/position_delta_serial.md
Name: position_delta_serial

Overview:
- Bit-serial subtractor that computes the signed displacement between a commanded position and the current ship position: delta = target - current.
- It is the reverse-direction counterpart of the module's add/accumulate datapath. It subtracts using a single full-adder cell and a borrow/carry flip-flop, one bit per clock, LSB first.
- It sits between the command latch and the thruster sequencer. The sequencer consumes the magnitude and direction of the delta.

Parameters:
- WIDTH, 3, bit width of the position operands and of the magnitude result (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- target  input  WIDTH  commanded position, unsigned; captured on accepted start
- current  input  WIDTH  present position, unsigned; captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when the result is valid
- magnitude  output  WIDTH  |target - current|; held until the next accepted start
- dir  output  1  0 = move forward (target >= current), 1 = move back
- zero  output  1  1 when target == current

Behaviour:
- Reset (synchronous, rst high at a posedge): state=IDLE; busy=0, done=0, magnitude=0, dir=0, zero=1; operand/result shift registers and carry flop cleared. rst has priority over all other inputs, including mid-operation; any in-flight result is discarded and no done is issued.
- FSM states: IDLE, SUB, NEG, DONE.
- IDLE: start=1 latches target into A and current into B, sets carry=1 (two's-complement subtract: A + ~B + 1), clears bit counter, and goes to SUB. busy rises the cycle after start.
- SUB: each cycle runs A[0] + ~B[0] + carry through one full-adder cell.
  - The sum shifts into result MSB; A and B shift right; carry updates.
  - After WIDTH cycles, final carry=1 means no borrow (dir=0) and the FSM goes to DONE. Final carry=0 means borrow (dir=1) and the FSM goes to NEG.
- NEG: serially two's-complement negates the result (invert and add 1 via the same cell, carry preset to 1) over WIDTH cycles, then goes to DONE. Magnitude is always positive, range 0..2^WIDTH-1.
- DONE: lasts one cycle.
  - magnitude, dir and zero update; done=1, busy=0.
  - zero = (magnitude == 0).
  - Returns to IDLE.
- Latency from start sample to done:
  - WIDTH+1 cycles when target >= current.
  - 2*WIDTH+1 cycles when target < current.
- start while busy, or in the DONE cycle, is ignored; no queuing.
- start in the same cycle as rst: reset wins and start is dropped.
- target and current may change freely after capture without affecting the in-flight result.
- Outputs magnitude, dir and zero change only in the DONE cycle or on reset.
- Width rule: all arithmetic is modulo 2^WIDTH within the serial path. The borrow is taken from the final carry, so the full unsigned range gives the exact magnitude; no overflow case exists.

Test Plan:
- Reset: assert rst 2 cycles with start=1 -> busy=0, done=0, magnitude=0, dir=0, zero=1; no done afterwards.
- Forward, WIDTH=3: target=6, current=2, start pulse -> done exactly 4 cycles later; magnitude=4, dir=0, zero=0.
- Backward: target=1, current=7 -> done 7 cycles after start; magnitude=6, dir=1, zero=0.
- Equal and extremes:
  - target=5, current=5 -> magnitude=0, dir=0, zero=1.
  - target=0, current=7 -> magnitude=7, dir=1.
  - target=7, current=0 -> magnitude=7, dir=0.
- Protocol: start held high continuously, target=3, current=0 -> one result per IDLE entry (done every 5 cycles). Operands changed while busy do not alter the result (3).
- Reset mid-operation: target=0, current=4, assert rst during NEG -> no done pulse, outputs return to reset values. A following start with target=4, current=0 gives magnitude=4, dir=0.
